// File: rtl/cga_pixel_serializer_pkg.sv
// Shared types and constants for the CGA pixel serializer: display modes,
// fetch-buffer record layout and slot/step sizing.
package cga_pixel_serializer_pkg;

  localparam int SLOTS_NARROW = 8;
  localparam int SLOTS_WIDE   = 16;
  localparam int CNT_W        = 5;
  localparam int STEP_1BPP    = 1;
  localparam int STEP_2BPP    = 2;
  localparam int FONT_LAT_MIN = 1;
  localparam int FONT_LAT_MAX = 2;

  typedef enum logic [1:0] {
    MODE_TEXT80 = 2'd0,
    MODE_TEXT40 = 2'd1,
    MODE_GFX320 = 2'd2,
    MODE_GFX640 = 2'd3
  } pix_mode_e;

  typedef struct packed {
    logic [15:0] vram;
    logic        grph;
    logic        mode_640;
    logic        hires;
    logic        de;
    logic        hs;
    logic        vs;
    logic        cur;
  } fetch_t;

  localparam int FETCH_W = $bits(fetch_t);

  function automatic pix_mode_e decode_mode(input logic grph, input logic m640,
                                            input logic hires);
    if (grph) return m640 ? MODE_GFX640 : MODE_GFX320;
    return hires ? MODE_TEXT80 : MODE_TEXT40;
  endfunction

  function automatic logic [CNT_W-1:0] slots_per_char(input pix_mode_e m);
    return (m == MODE_TEXT80) ? CNT_W'(SLOTS_NARROW) : CNT_W'(SLOTS_WIDE);
  endfunction

endpackage

// File: rtl/cga_pixel_serializer_fetch_buf.sv
// Fetch buffer: captures the VRAM word, mode and sideband at a load edge,
// drives the font ROM address and grabs font data after the ROM latency.
module cga_pixel_serializer_fetch_buf
  import cga_pixel_serializer_pkg::*;
#(
  parameter int ROW_BITS     = 3,
  parameter int FONT_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load_i,
  input  logic [FETCH_W-1:0]    fetch_i,
  input  logic [7:0]            char_i,
  input  logic [ROW_BITS-1:0]   row_addr_i,
  input  logic [7:0]            font_data_i,
  output logic [FETCH_W-1:0]    fetch_o,
  output logic [7:0]            font_o,
  output logic [8+ROW_BITS-1:0] font_addr_o
);

  // Out-of-range latencies are clamped to the supported window.
  localparam int LAT = (FONT_LATENCY < FONT_LAT_MIN) ? FONT_LAT_MIN :
                       (FONT_LATENCY > FONT_LAT_MAX) ? FONT_LAT_MAX : FONT_LATENCY;

  logic [LAT-1:0]          pend_q, pend_d;
  logic [FETCH_W-1:0]      fetch_q;
  logic [7:0]              font_q;
  logic [8+ROW_BITS-1:0]   font_addr_q;
  logic                    capture;

  assign pend_d  = LAT'({pend_q, load_i});
  assign capture = pend_q[LAT-1];

  always_ff @(posedge clk) begin
    if (reset) begin
      pend_q      <= '0;
      fetch_q     <= '0;
      font_q      <= '0;
      font_addr_q <= '0;
    end else begin
      pend_q <= pend_d;
      if (load_i) begin
        fetch_q     <= fetch_i;
        font_addr_q <= {char_i, row_addr_i};
      end
      if (capture) font_q <= font_data_i;
    end
  end

  // Bypass so a load landing on the capture edge still sees the fresh glyph.
  assign font_o      = capture ? font_data_i : font_q;
  assign fetch_o     = fetch_q;
  assign font_addr_o = font_addr_q;

endmodule

// File: rtl/cga_pixel_serializer.sv
// CGA pixel serializer: shifts text glyphs or graphics words out MSB-first,
// one character behind the fetch, with attribute and sideband kept aligned.
module cga_pixel_serializer
  import cga_pixel_serializer_pkg::*;
#(
  parameter int ROW_BITS     = 3,
  parameter int FONT_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  pix_en,
  input  logic                  char_load,
  input  logic [15:0]           vram_data,
  input  logic [ROW_BITS-1:0]   row_addr,
  input  logic                  grph_mode,
  input  logic                  mode_640,
  input  logic                  hires_text,
  input  logic                  display_enable_in,
  input  logic                  hsync_in,
  input  logic                  vsync_in,
  input  logic                  cursor_in,
  input  logic [7:0]            font_data,
  output logic [8+ROW_BITS-1:0] font_addr,
  output logic [7:0]            att_byte,
  output logic                  pix_in,
  output logic                  c0,
  output logic                  c1,
  output logic                  pix_640,
  output logic                  display_enable,
  output logic                  hsync,
  output logic                  vsync,
  output logic                  cursor
);

  logic               load;
  fetch_t             fetch_in, prev;
  logic [FETCH_W-1:0] prev_bits;
  logic [7:0]         prev_font;

  logic [15:0]        sr_q, sr_d;
  pix_mode_e          mode_q, mode_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [7:0]         att_q, att_d;
  logic [3:0]         sb_q, sb_d;

  assign load     = char_load & pix_en;
  assign fetch_in = '{vram: vram_data, grph: grph_mode, mode_640: mode_640,
                      hires: hires_text, de: display_enable_in, hs: hsync_in,
                      vs: vsync_in, cur: cursor_in};

  cga_pixel_serializer_fetch_buf #(
    .ROW_BITS     (ROW_BITS),
    .FONT_LATENCY (FONT_LATENCY)
  ) u_fetch_buf (
    .clk         (clk),
    .reset       (reset),
    .load_i      (load),
    .fetch_i     (fetch_in),
    .char_i      (vram_data[7:0]),
    .row_addr_i  (row_addr),
    .font_data_i (font_data),
    .fetch_o     (prev_bits),
    .font_o      (prev_font),
    .font_addr_o (font_addr)
  );

  assign prev = fetch_t'(prev_bits);

  always_comb begin
    sr_d   = sr_q;
    mode_d = mode_q;
    cnt_d  = cnt_q;
    att_d  = att_q;
    sb_d   = sb_q;
    if (load) begin
      mode_d = decode_mode(prev.grph, prev.mode_640, prev.hires);
      if (prev.grph) begin
        sr_d  = {prev.vram[7:0], prev.vram[15:8]};
        att_d = 8'h00;
      end else begin
        sr_d  = {prev_font, 8'h00};
        att_d = prev.vram[15:8];
      end
      cnt_d = '0;
      sb_d  = {prev.de, prev.hs, prev.vs, prev.cur};
    end else if (pix_en && (cnt_q < slots_per_char(mode_q))) begin
      // Wide modes advance on the second slot of each pixel.
      cnt_d = cnt_q + 1'b1;
      unique case (mode_q)
        MODE_TEXT80, MODE_GFX640: sr_d = sr_q << STEP_1BPP;
        MODE_TEXT40:              if (cnt_q[0]) sr_d = sr_q << STEP_1BPP;
        default:                  if (cnt_q[0]) sr_d = sr_q << STEP_2BPP;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sr_q   <= '0;
      mode_q <= MODE_TEXT80;
      cnt_q  <= '0;
      att_q  <= '0;
      sb_q   <= '0;
    end else begin
      sr_q   <= sr_d;
      mode_q <= mode_d;
      cnt_q  <= cnt_d;
      att_q  <= att_d;
      sb_q   <= sb_d;
    end
  end

  assign pix_in   = ((mode_q == MODE_TEXT80) || (mode_q == MODE_TEXT40)) & sr_q[15];
  assign c1       = (mode_q == MODE_GFX320) & sr_q[15];
  assign c0       = (mode_q == MODE_GFX320) & sr_q[14];
  assign pix_640  = (mode_q == MODE_GFX640) & sr_q[15];
  assign att_byte = att_q;
  assign {display_enable, hsync, vsync, cursor} = sb_q;

endmodule

// File: tb/tb_cga_pixel_serializer.sv
// Bench for cga_pixel_serializer: latency-1 and latency-2 instances run in
// lock-step against a slot-indexed reference model of the character stream.
module tb_cga_pixel_serializer;

  logic        clk;
  logic        reset, pix_en, char_load;
  logic [15:0] vram_data;
  logic [2:0]  row_addr;
  logic        grph_mode, mode_640, hires_text;
  logic        de_in, hs_in, vs_in, cur_in;

  logic [10:0] font_addr_a, font_addr_b;
  logic [7:0]  font_data_a, font_data_b;
  logic [7:0]  att_a, att_b;
  logic        pix_in_a, c0_a, c1_a, p640_a, de_a, hs_a, vs_a, cur_a;
  logic        pix_in_b, c0_b, c1_b, p640_b, de_b, hs_b, vs_b, cur_b;

  logic [7:0]  rom [0:2047];

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic [15:0] vram;
    logic [7:0]  font;
    logic        grph, m640, hires, de, hs, vs, cur;
  } rec_t;

  rec_t        f_m, s_rec;
  int          s_m;
  logic [10:0] fa_m;

  logic [15:0] hist_pix, hist_p640;
  logic [31:0] hist_c;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Font ROM models: combinational for latency 1, one register for latency 2.
  assign font_data_a = rom[font_addr_a];
  always @(posedge clk) font_data_b <= rom[font_addr_b];

  cga_pixel_serializer #(.ROW_BITS(3), .FONT_LATENCY(1)) dut_a (
    .clk(clk), .reset(reset), .pix_en(pix_en), .char_load(char_load),
    .vram_data(vram_data), .row_addr(row_addr), .grph_mode(grph_mode),
    .mode_640(mode_640), .hires_text(hires_text), .display_enable_in(de_in),
    .hsync_in(hs_in), .vsync_in(vs_in), .cursor_in(cur_in),
    .font_data(font_data_a), .font_addr(font_addr_a), .att_byte(att_a),
    .pix_in(pix_in_a), .c0(c0_a), .c1(c1_a), .pix_640(p640_a),
    .display_enable(de_a), .hsync(hs_a), .vsync(vs_a), .cursor(cur_a));

  cga_pixel_serializer #(.ROW_BITS(3), .FONT_LATENCY(2)) dut_b (
    .clk(clk), .reset(reset), .pix_en(pix_en), .char_load(char_load),
    .vram_data(vram_data), .row_addr(row_addr), .grph_mode(grph_mode),
    .mode_640(mode_640), .hires_text(hires_text), .display_enable_in(de_in),
    .hsync_in(hs_in), .vsync_in(vs_in), .cursor_in(cur_in),
    .font_data(font_data_b), .font_addr(font_addr_b), .att_byte(att_b),
    .pix_in(pix_in_b), .c0(c0_b), .c1(c1_b), .pix_640(p640_b),
    .display_enable(de_b), .hsync(hs_b), .vsync(vs_b), .cursor(cur_b));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Expected {pix_in, c1, c0, pix_640} for slot s of a displayed character.
  function automatic logic [3:0] exp_pix(input rec_t r, input int s);
    logic [3:0]  o;
    logic [15:0] w;
    int          idx;
    o = 4'b0000;
    w = {r.vram[7:0], r.vram[15:8]};
    if (!r.grph) begin
      idx = r.hires ? s : s / 2;
      if (idx < 8) o[3] = r.font[7-idx];
    end else if (r.m640) begin
      if (s < 16) o[0] = w[15-s];
    end else if (s < 16) begin
      idx  = s / 2;
      o[2] = w[15-2*idx];
      o[1] = w[14-2*idx];
    end
    return o;
  endfunction

  task automatic model_update();
    if (reset) begin
      f_m = '0; s_rec = '0; s_m = 0; fa_m = '0;
    end else if (pix_en && char_load) begin
      s_rec  = f_m;
      f_m.vram  = vram_data;
      f_m.font  = rom[{vram_data[7:0], row_addr}];
      f_m.grph  = grph_mode; f_m.m640 = mode_640; f_m.hires = hires_text;
      f_m.de    = de_in; f_m.hs = hs_in; f_m.vs = vs_in; f_m.cur = cur_in;
      s_m  = 0;
      fa_m = {vram_data[7:0], row_addr};
    end else if (pix_en && s_m < 100) begin
      s_m++;
    end
  endtask

  task automatic check_outs(input string who, input logic [10:0] fa, input logic [7:0] att,
                            input logic pi, input logic cc1, input logic cc0, input logic p6,
                            input logic de, input logic hs, input logic vs, input logic cu);
    logic [3:0] e;
    e = exp_pix(s_rec, s_m);
    check({who, "_font_addr"}, 32'(fa), 32'(fa_m));
    check({who, "_att_byte"}, 32'(att), 32'(s_rec.grph ? 8'h00 : s_rec.vram[15:8]));
    check({who, "_pix_in"}, 32'(pi), 32'(e[3]));
    check({who, "_c1"}, 32'(cc1), 32'(e[2]));
    check({who, "_c0"}, 32'(cc0), 32'(e[1]));
    check({who, "_pix_640"}, 32'(p6), 32'(e[0]));
    check({who, "_sideband"}, 32'({de, hs, vs, cu}),
          32'({s_rec.de, s_rec.hs, s_rec.vs, s_rec.cur}));
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    check_outs("a", font_addr_a, att_a, pix_in_a, c1_a, c0_a, p640_a, de_a, hs_a, vs_a, cur_a);
    check_outs("b", font_addr_b, att_b, pix_in_b, c1_b, c0_b, p640_b, de_b, hs_b, vs_b, cur_b);
    hist_pix  = {hist_pix[14:0], pix_in_a};
    hist_p640 = {hist_p640[14:0], p640_a};
    hist_c    = {hist_c[29:0], c1_a, c0_a};
  endtask

  task automatic rand_inputs();
    vram_data  = 16'($urandom);
    row_addr   = 3'($urandom);
    {grph_mode, mode_640, hires_text} = 3'($urandom);
    {de_in, hs_in, vs_in, cur_in} = 4'($urandom);
  endtask

  // One character: a load slot followed by nslots-1 plain pixel slots.
  task automatic run_char(input logic [15:0] v, input logic [2:0] r, input logic [2:0] mode,
                          input logic [3:0] sb, input int nslots, input bit noisy);
    $display("[TB] char vram=%h row=%0d mode=%b sb=%b slots=%0d", v, r, mode, sb, nslots);
    for (int k = 0; k < nslots; k++) begin
      if (noisy) begin
        repeat ($urandom_range(0, 2)) begin
          pix_en = 1'b0; char_load = 1'($urandom); rand_inputs();
          step();
        end
      end
      pix_en = 1'b1;
      char_load = (k == 0);
      if (k == 0) begin
        vram_data = v; row_addr = r;
        {grph_mode, mode_640, hires_text} = mode;
        {de_in, hs_in, vs_in, cur_in} = sb;
      end else if (noisy) begin
        rand_inputs();
      end
      step();
    end
  endtask

  initial begin
    logic [2:0] m;
    int         n;
    for (int i = 0; i < 2048; i++) rom[i] = 8'($urandom);
    rom[11'h208] = 8'h18;
    hist_pix = '0; hist_p640 = '0; hist_c = '0;
    f_m = '0; s_rec = '0; s_m = 0; fa_m = '0;
    reset = 1'b1; pix_en = 1'b0; char_load = 1'b0;
    vram_data = '0; row_addr = '0; grph_mode = 1'b0; mode_640 = 1'b0; hires_text = 1'b0;
    de_in = 1'b0; hs_in = 1'b0; vs_in = 1'b0; cur_in = 1'b0;
    repeat (3) step();
    reset = 1'b0;
    repeat (32) step();
    check("idle_font_addr", 32'(font_addr_a), 32'h0);

    // 80-column text
    run_char(16'h1F41, 3'd0, 3'b001, 4'b1000, 8, 1'b0);
    check("txt80_font_addr", 32'(font_addr_a), 32'h208);
    run_char(16'h1F41, 3'd0, 3'b001, 4'b1000, 8, 1'b0);
    check("txt80_seq", 32'(hist_pix[7:0]), 32'h18);
    check("txt80_att", 32'(att_a), 32'h1F);

    // 40-column text
    run_char(16'h1F41, 3'd0, 3'b000, 4'b1000, 16, 1'b0);
    run_char(16'h1F41, 3'd0, 3'b000, 4'b1000, 16, 1'b0);
    check("txt40_seq", 32'(hist_pix), 32'h03C0);

    // 320 graphics
    run_char(16'h1BE4, 3'd0, 3'b100, 4'b1000, 16, 1'b0);
    run_char(16'h1BE4, 3'd0, 3'b100, 4'b1000, 16, 1'b0);
    check("gfx320_seq", hist_c, 32'hFA5005AF);
    check("gfx320_pix_in", 32'(hist_pix), 32'h0);
    check("gfx320_pix_640", 32'(hist_p640), 32'h0);

    // 640 graphics
    run_char(16'h00AA, 3'd0, 3'b110, 4'b1000, 16, 1'b0);
    run_char(16'h00AA, 3'd0, 3'b110, 4'b1000, 16, 1'b0);
    check("gfx640_seq", 32'(hist_p640), 32'hAA00);

    // hsync on one character, early reload, missing reload
    run_char(16'h1F41, 3'd0, 3'b001, 4'b1100, 8, 1'b0);
    run_char(16'h2C33, 3'd5, 3'b001, 4'b1000, 8, 1'b0);
    run_char(16'h4E7A, 3'd2, 3'b001, 4'b1000, 5, 1'b0);
    run_char(16'h5AC3, 3'd1, 3'b110, 4'b1001, 8, 1'b0);
    run_char(16'hFF0F, 3'd0, 3'b110, 4'b0000, 16, 1'b0);
    run_char(16'h1234, 3'd3, 3'b000, 4'b0010, 24, 1'b0);
    run_char(16'h5678, 3'd4, 3'b001, 4'b0000, 8, 1'b0);

    // Randomized stream with ignored loads, mid-character mode churn and resets
    repeat (250) begin
      if ($urandom_range(0, 39) == 0) begin
        reset = 1'b1; pix_en = 1'($urandom); char_load = 1'($urandom);
        step();
        reset = 1'b0;
      end
      m = 3'($urandom);
      if ($urandom_range(0, 3) == 0) n = $urandom_range(3, 24);
      else n = (!m[2] && m[0]) ? 8 : 16;
      run_char(16'($urandom), 3'($urandom), m, 4'($urandom), n, 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
